alu_seq_unit: RTL
=================

Name: alu_seq_unit

Overview:
- Parametrised, multi-cycle successor to the core ALU, for 16/24/32-bit datapath variants of the CPU family.
- Adds and subtracts one 4-bit digit per cycle, in binary or packed BCD, over WIDTH/4 digits.
- Rotates through carry by a programmable count, one bit per cycle.
- Sits behind the operand muxes, which stay external; start/busy/done handshake to the sequencer; honours the global `ready` stall.

Parameters:
- WIDTH, 16, datapath width in bits; multiple of 4, >= 8.
- DIGITS, WIDTH/4, derived nibble count; not overridden.
- SHW, $clog2(WIDTH), width of the shift-count port.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- ready  in  1  global clock enable; low freezes all state.
- start  in  1  request; accepted only when state=IDLE and ready=1.
- op  in  4  operation code (shared constants).
- dec  in  1  decimal mode for ADC/SBC.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; SBC inverts it internally.
- c_in  in  1  carry in; for SBC, 1 = no borrow.
- shamt  in  SHW  rotate count.
- busy  out  1  high while state=RUN.
- done  out  1  one-cycle pulse; result and flags valid from this cycle.
- result  out  WIDTH  registered result.
- carry_out  out  1  final carry.
- half_carry_out  out  1  carry out of digit 0.
- overflow_out  out  1  signed overflow, ADC/SBC only.
- zero_out  out  1  result==0.
- negative_out  out  1  result[WIDTH-1].

Behaviour:
- Opcodes: ORA=0, AND=1, EOR=2, ADC=3, SBC=4, ROR=5, ROL=6, PSA=7. Others behave as PSA.
- FSM states: IDLE, RUN.
- Accept (IDLE, start=1, ready=1, clock edge): latch op, dec, a, b' (b' = ~b for SBC, else b), c_in, shamt. Load step counter = steps-1. Go to RUN.
- Step counts: logic/PSA = 1; ADC/SBC = DIGITS; ROR/ROL = max(shamt,1).
- RUN: each edge with ready=1 performs one step and decrements the counter. On the edge where counter==0: state -> IDLE, done <= 1, flags update.
- done clears on the next edge unconditionally.
- Latency: accept to done high = steps ready-edges.
- Back-to-back: start in the done cycle is accepted.
- ADC/SBC digit step k (k = 0..DIGITS-1, LSB first): s = a[k] + b'[k] + cy (5 bits).
  - dec & ADC: if s>9, digit = s+6 (mod 16), cy=1; else digit = s, cy = s[4].
  - dec & SBC: digit = s mod 16, cy = s[4]; if cy=0, digit = digit+10 (mod 16).
  - binary: digit = s[3:0], cy = s[4].
  - After step 0, half_carry_out is latched from cy.
- ADC/SBC flags: carry_out = final cy. overflow_out = (a[MSB]==b'[MSB]) & (result[MSB]!=a[MSB]), evaluated on the final (corrected) result.
- ROR step: {result,c} <= {c,result} (WIDTH+1-bit rotate). ROL is the mirror. Initial register = a, carry = c_in.
  - shamt=0: one step, no rotation; result=a, carry_out=c_in.
  - overflow_out=0.
- Logic ops: ORA/EOR/PSA carry_out=0. AND carry_out = |result (branch bit-test hack retained). overflow_out=0.
- half_carry_out = 0 for all non-ADC/SBC ops.
- zero_out and negative_out update at done for all ops.
- start while RUN: ignored; no queueing.
- ready=0: no state, counter or output change; done held if it was high.
- reset_n=0 (any state, mid-operation included): next edge -> IDLE, busy=0, done=0, result=0, all flags 0; partial result discarded.
- Outputs hold between operations.

Decomposition:
- Opcode constants and state encodings go in the shared include header, as `ALU_*` macros extended with ROL.
- One combinational sub-module, alu_digit_adder: 4-bit inputs, cy_in, dec, sub -> digit, cy_out. It is instanced once and reused every cycle.

Test Plan:
- WIDTH=16, ADC, dec=1, a=0x0999, b=0x0001, c_in=0 -> done 4 ready-edges after accept; result 0x1000, carry 0, half_carry 1, zero 0.
- ADC, dec=1, a=0x9999, b=0x0001, c_in=0 -> result 0x0000, carry 1, zero 1. Then SBC, dec=1, a=0x1000, b=0x0001, c_in=1 -> result 0x0999, carry 1.
- ADC, dec=0, a=0x7FFF, b=0x0001, c_in=0 -> result 0x8000, overflow 1, negative 1, carry 0. SBC, dec=0, a=0x0000, b=0x0001, c_in=1 -> result 0xFFFF, carry 0.
- ROR, a=0x0001, c_in=0, shamt=3 -> done after 3 edges, result 0x4000, carry 0. ROL with shamt=0 -> result=a after 1 edge.
- Mid-ADC: ready=0 for 5 cycles -> busy stays 1, nothing changes, done delayed by exactly 5 cycles. start pulsed while busy -> ignored.
- reset_n=0 during step 2 of ADC -> IDLE next edge, all outputs 0. AND a=0x00F0, b=0x0F00 -> result 0, carry 0. Back-to-back start in the done cycle -> accepted.

Source files
------------

// File: rtl/alu_seq_unit_pkg.sv
// Shared opcode constants, FSM encoding and helpers for the sequential ALU.
package alu_seq_unit_pkg;

    localparam logic [3:0] ALU_ORA = 4'd0;
    localparam logic [3:0] ALU_AND = 4'd1;
    localparam logic [3:0] ALU_EOR = 4'd2;
    localparam logic [3:0] ALU_ADC = 4'd3;
    localparam logic [3:0] ALU_SBC = 4'd4;
    localparam logic [3:0] ALU_ROR = 4'd5;
    localparam logic [3:0] ALU_ROL = 4'd6;
    localparam logic [3:0] ALU_PSA = 4'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic is_arith(input logic [3:0] op);
        return (op == ALU_ADC) || (op == ALU_SBC);
    endfunction

endpackage

// File: rtl/alu_digit_adder.sv
// One-nibble binary/packed-BCD adder used once per cycle by the sequential ALU.
module alu_digit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cy_in,
    input  logic       dec,
    input  logic       sub,
    output logic [3:0] digit,
    output logic       cy_out
);

    logic [4:0] sum_s;

    // Raw 5-bit sum followed by the decimal correction for the selected direction
    always_comb begin
        sum_s  = {1'b0, a} + {1'b0, b} + {4'b0000, cy_in};
        digit  = sum_s[3:0];
        cy_out = sum_s[4];
        if (dec && !sub) begin
            if (sum_s > 5'd9) begin
                digit  = sum_s[3:0] + 4'd6;
                cy_out = 1'b1;
            end else begin
                digit  = sum_s[3:0];
                cy_out = sum_s[4];
            end
        end else if (dec && sub) begin
            // a borrow out of a BCD digit leaves a value 6 above the true 10's complement
            if (!sum_s[4]) begin
                digit = sum_s[3:0] + 4'd10;
            end else begin
                digit = sum_s[3:0];
            end
        end else begin
            digit  = sum_s[3:0];
            cy_out = sum_s[4];
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU: nibble-serial binary/BCD add/sub, bit-serial rotate through carry,
// single-step logic ops, with start/busy/done handshake and global ready stall.
module alu_seq_unit
    import alu_seq_unit_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = WIDTH / 4,
    parameter int SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ready,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             dec,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             half_carry_out,
    output logic             overflow_out,
    output logic             zero_out,
    output logic             negative_out
);

    localparam logic [SHW-1:0] CNT_ZERO  = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE   = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0] CNT_FIRST = SHW'(DIGITS - 1);

    state_t           state_r, next_state_s;
    logic [3:0]       op_r;
    logic             dec_r, cy_r, hc_r, a_msb_r, b_msb_r;
    logic [WIDTH-1:0] a_r, b_r, work_r;
    logic [SHW-1:0]   shamt_r, cnt_r, load_cnt_s;
    logic             accept_s, last_s;
    logic [WIDTH-1:0] step_work_s;
    logic             step_cy_s;
    logic [3:0]       dig_s;
    logic             dig_cy_s;

    alu_digit_adder u_digit (
        .a      (a_r[3:0]),
        .b      (b_r[3:0]),
        .cy_in  (cy_r),
        .dec    (dec_r),
        .sub    (op_r == ALU_SBC),
        .digit  (dig_s),
        .cy_out (dig_cy_s)
    );

    assign busy = (state_r == ST_RUN);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; ready low freezes everything
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ready && start) begin
                    next_state_s = ST_RUN;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ready && (cnt_r == CNT_ZERO)) begin
                    next_state_s = ST_IDLE;
                    last_s       = 1'b1;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Step count minus one for the operation being accepted
    always_comb begin
        load_cnt_s = CNT_ZERO;
        case (op)
            ALU_ADC, ALU_SBC: load_cnt_s = CNT_FIRST;
            ALU_ROR, ALU_ROL: begin
                if (shamt != CNT_ZERO) begin
                    load_cnt_s = shamt - CNT_ONE;
                end else begin
                    load_cnt_s = CNT_ZERO;
                end
            end
            default: load_cnt_s = CNT_ZERO;
        endcase
    end

    // One datapath step: next working value and carry
    always_comb begin
        step_work_s = work_r;
        step_cy_s   = cy_r;
        case (op_r)
            ALU_ADC, ALU_SBC: begin
                // digits enter at the top so the word is aligned after the last step
                step_work_s = {dig_s, work_r[WIDTH-1:4]};
                step_cy_s   = dig_cy_s;
            end
            ALU_ROR: begin
                if (shamt_r != CNT_ZERO) begin
                    step_work_s = {cy_r, work_r[WIDTH-1:1]};
                    step_cy_s   = work_r[0];
                end else begin
                    step_work_s = work_r;
                    step_cy_s   = cy_r;
                end
            end
            ALU_ROL: begin
                if (shamt_r != CNT_ZERO) begin
                    step_work_s = {work_r[WIDTH-2:0], cy_r};
                    step_cy_s   = work_r[WIDTH-1];
                end else begin
                    step_work_s = work_r;
                    step_cy_s   = cy_r;
                end
            end
            ALU_ORA: begin
                step_work_s = a_r | b_r;
                step_cy_s   = 1'b0;
            end
            ALU_AND: begin
                // carry doubles as a bit-test result for branch sequences
                step_work_s = a_r & b_r;
                step_cy_s   = |(a_r & b_r);
            end
            ALU_EOR: begin
                step_work_s = a_r ^ b_r;
                step_cy_s   = 1'b0;
            end
            default: begin
                step_work_s = a_r;
                step_cy_s   = 1'b0;
            end
        endcase
    end

    // Operand latch, per-step datapath update and output/flag registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_r           <= 4'd0;
            dec_r          <= 1'b0;
            a_r            <= {WIDTH{1'b0}};
            b_r            <= {WIDTH{1'b0}};
            cy_r           <= 1'b0;
            shamt_r        <= CNT_ZERO;
            cnt_r          <= CNT_ZERO;
            work_r         <= {WIDTH{1'b0}};
            hc_r           <= 1'b0;
            a_msb_r        <= 1'b0;
            b_msb_r        <= 1'b0;
            done           <= 1'b0;
            result         <= {WIDTH{1'b0}};
            carry_out      <= 1'b0;
            half_carry_out <= 1'b0;
            overflow_out   <= 1'b0;
            zero_out       <= 1'b0;
            negative_out   <= 1'b0;
        end else if (ready) begin
            done <= 1'b0;
            if (accept_s) begin
                op_r    <= op;
                dec_r   <= dec;
                a_r     <= a;
                b_r     <= (op == ALU_SBC) ? ~b : b;
                cy_r    <= c_in;
                shamt_r <= shamt;
                cnt_r   <= load_cnt_s;
                work_r  <= a;
                hc_r    <= 1'b0;
                a_msb_r <= a[WIDTH-1];
                b_msb_r <= (op == ALU_SBC) ? ~b[WIDTH-1] : b[WIDTH-1];
            end else if (state_r == ST_RUN) begin
                work_r <= step_work_s;
                cy_r   <= step_cy_s;
                cnt_r  <= cnt_r - CNT_ONE;
                if (is_arith(op_r)) begin
                    a_r <= a_r >> 4'd4;
                    b_r <= b_r >> 4'd4;
                end
                if (is_arith(op_r) && (cnt_r == CNT_FIRST)) begin
                    hc_r <= dig_cy_s;
                end
                if (last_s) begin
                    done           <= 1'b1;
                    result         <= step_work_s;
                    carry_out      <= step_cy_s;
                    half_carry_out <= is_arith(op_r) ? hc_r : 1'b0;
                    overflow_out   <= is_arith(op_r) &&
                                      (a_msb_r == b_msb_r) &&
                                      (step_work_s[WIDTH-1] != a_msb_r);
                    zero_out       <= (step_work_s == {WIDTH{1'b0}});
                    negative_out   <= step_work_s[WIDTH-1];
                end
            end
        end
    end

endmodule
